ram_write_arbiter: RTL and testbench
====================================

// Module: ram_write_arbiter
// PURPOSE
// - Shares the single write port (WA/WD/WE) of the 10x15-bit register RAM between two requesters, A and B.
// - Typical requesters are ALU write-back (A) and the program/data loader (B).
// - Grants by round-robin, registers the write command and rejects out-of-range addresses.
// - Optionally clears every RAM word after reset. Sits directly in front of the RAM write port; read ports are untouched.
// PARAMETERS
// - DEPTH  10  number of implemented RAM words; valid addresses 0..DEPTH-1
// - AW     4   address width
// - DW     15  data width
// PORTS
// - ramarbCLK   in   1   clock, rising edge; same clock as the RAM
// - ramarbRSTN  in   1   reset, asynchronous, active-low
// - ramarbREQA  in   1   requester A write request; held until ramarbGNTA
// - ramarbWAA   in   AW  requester A address; stable while REQA=1
// - ramarbWDA   in   DW  requester A data; stable while REQA=1
// - ramarbGNTA  out  1   1-cycle pulse: A's request consumed
// - ramarbREQB, ramarbWAB, ramarbWDB, ramarbGNTB: same as the A ports, for requester B
// - ramarbERR   out  1   1-cycle pulse with GNTx: the consumed request had address >= DEPTH and was dropped
// - ramarbBUSY  out  1   1 while in INIT; requests are ignored
// - ramarbWA    out  AW  to RAM write address
// - ramarbWD    out  DW  to RAM write data
// - ramarbWE    out  1   to RAM write enable
// BEHAVIOUR
// - Clocking and reset
//   - One clock. Reset is asynchronous, active-low; all flops clear immediately on RSTN=0.
//   - Reset values: WE=0, WA=0, WD=0, GNTA=0, GNTB=0, ERR=0, last-grant pointer=B, state=INIT (or ARB without the feature).
//   - BUSY=(state==INIT). All RAM-side outputs and GNT/ERR are registered.
// - State machine
//   - INIT: WE=1, WD=0, WA=init counter (0..DEPTH-1, +1 per cycle). Go to ARB after WA=DEPTH-1. Requests are ignored but stay pending.
//   - ARB: if no request, stay; WE=0.
//     - One request: select it. Both requests: select the requester that was not granted last. The first contest after reset goes to A.
//     - On leaving ARB, register WA/WD from the selected requester and update the last-grant pointer. Go to WRITE.
//   - WRITE (exactly 1 cycle): GNTx=1 for the selected requester.
//     - WE=1 if the latched address < DEPTH. Otherwise WE=0 and ERR=1.
//     - The RAM captures on the edge that ends WRITE. Always return to ARB.
// - Handshake and latency
//   - The requester drops or changes REQ/addr/data on the edge that ends its GNT cycle.
//   - A REQ high in ARB gets GNT and WE one cycle later; the RAM word is visible on the reads the cycle after that.
//   - Maximum throughput: 1 write per 2 cycles. A requester may re-request in the ARB cycle right after its GNT.
//   - Two continuous requesters alternate A,B,A,B. Neither waits more than 4 cycles from ARB entry.
// - Boundary conditions
//   - Address >= DEPTH (10..15): consumed, no write, ERR pulse. The pointer still advances.
//   - REQ dropped before grant: no write. REQ sampled only in ARB.
//   - Reset mid-INIT or mid-WRITE: the in-flight write is aborted (WE=0 immediately). INIT restarts from address 0.
//   - WA/WD hold their last values when WE=0.
// CONFIGURATION
// - RAMARB_INIT_EN defined: INIT state exists. After every reset, DEPTH cycles of writes of 0 to words 0..DEPTH-1, BUSY=1 throughout.
// - RAMARB_INIT_EN undefined: no INIT state and no init counter. Reset goes straight to ARB.
//   BUSY is tied 0; RAM contents after reset are whatever the RAM flops hold.
// TESTING
// 1. Reset release, INIT_EN: BUSY=1 for 10 cycles; WE=1 with WA=0..9 and WD=0; then BUSY=0. Readback of all words = 0.
// 2. REQA=1, WAA=3, WDA=15'h1234 in ARB: the next cycle has GNTA=1, WE=1, WA=3, WD=15'h1234. RAM[3] reads 15'h1234 afterwards.
// 3. REQA and REQB held continuously (A addr 1, B addr 2): grants alternate A,B,A,B starting with A, one GNT every 2 cycles, no double grant.
// 4. REQB=1, WAB=12: GNTB=1, ERR=1, WE=0; all RAM words unchanged.
// 5. RSTN pulsed low during WRITE, and separately at INIT address 5: WE drops at once with no write. INIT restarts at WA=0; a pending REQ is granted after INIT.
// 6. Build without RAMARB_INIT_EN: BUSY=0 from reset. A request in the first cycle after reset is granted in cycle 2.

Source files
------------

// File: rtl/ram_write_arbiter_if.sv
// Purpose : bundles the two requester ports and the RAM write port of ram_write_arbiter.
// Latency : n/a (signal bundle only).
// Backpress: requesters hold REQ/addr/data until their GNT pulse.
//
// Signals:
//   ramarbREQA/WAA/WDA, ramarbREQB/WAB/WDB : requester A/B request, address, data
//   ramarbGNTA/GNTB                         : one-cycle "request consumed" pulses
//   ramarbERR                               : pulses with GNTx when the address was out of range
//   ramarbBUSY                              : power-up clear in progress, requests ignored
//   ramarbWA/WD/WE                          : RAM write port
interface ram_write_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 15
);
    logic          ramarbREQA;
    logic [AW-1:0] ramarbWAA;
    logic [DW-1:0] ramarbWDA;
    logic          ramarbGNTA;
    logic          ramarbREQB;
    logic [AW-1:0] ramarbWAB;
    logic [DW-1:0] ramarbWDB;
    logic          ramarbGNTB;
    logic          ramarbERR;
    logic          ramarbBUSY;
    logic [AW-1:0] ramarbWA;
    logic [DW-1:0] ramarbWD;
    logic          ramarbWE;

    // Requester / RAM side.
    modport master (
        output ramarbREQA, ramarbWAA, ramarbWDA,
        output ramarbREQB, ramarbWAB, ramarbWDB,
        input  ramarbGNTA, ramarbGNTB, ramarbERR, ramarbBUSY,
        input  ramarbWA, ramarbWD, ramarbWE
    );

    // Arbiter side.
    modport slave (
        input  ramarbREQA, ramarbWAA, ramarbWDA,
        input  ramarbREQB, ramarbWAB, ramarbWDB,
        output ramarbGNTA, ramarbGNTB, ramarbERR, ramarbBUSY,
        output ramarbWA, ramarbWD, ramarbWE
    );
endinterface

// File: rtl/ram_write_arbiter.sv
// Purpose : round-robin arbiter sharing one RAM write port between requesters A and B.
// Latency : REQ seen in ARB -> GNT/WE on the next cycle; at most one write every 2 cycles.
// Backpress: a requester holds REQ/addr/data until GNT; requests wait (ignored) while BUSY.
//
// Ports:
//   ramarbCLK  : clock, rising edge, shared with the RAM
//   ramarbRSTN : asynchronous active-low reset
//   bus        : ram_write_arbiter_if.slave (requester ports, GNT/ERR/BUSY, RAM WA/WD/WE)
//
// Build option: RAMARB_INIT_EN -- when defined, every reset is followed by DEPTH
// cycles writing 0 to words 0..DEPTH-1 (BUSY=1). When undefined, reset goes
// straight to arbitration and BUSY is tied low.
module ram_write_arbiter #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 15
) (
    input  logic                  ramarbCLK,
    input  logic                  ramarbRSTN,
    ram_write_arbiter_if.slave    bus
);

`ifdef RAMARB_INIT_EN
    typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_WRITE} state_t;
    localparam state_t RST_STATE = ST_INIT;
`else
    typedef enum logic {ST_ARB, ST_WRITE} state_t;
    localparam state_t RST_STATE = ST_ARB;
`endif

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          gnta_q, gnta_d;
    logic          gntb_q, gntb_d;
    logic          err_q, err_d;
    logic          last_b_q, last_b_d;   // 1: B was granted most recently
`ifdef RAMARB_INIT_EN
    logic [AW-1:0] cnt_q, cnt_d;         // next word to clear
`endif

    logic          sel_a;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_ok;

    // A wins when it is the only requester, or when both ask and B went last.
    always_comb begin
        sel_a    = bus.ramarbREQA & (~bus.ramarbREQB | last_b_q);
        sel_addr = sel_a ? bus.ramarbWAA : bus.ramarbWAB;
        sel_data = sel_a ? bus.ramarbWDA : bus.ramarbWDB;
        sel_ok   = ({1'b0, sel_addr} < (AW+1)'(DEPTH));
    end

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        gnta_d   = 1'b0;
        gntb_d   = 1'b0;
        err_d    = 1'b0;
        last_b_d = last_b_q;
`ifdef RAMARB_INIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
`ifdef RAMARB_INIT_EN
            ST_INIT: begin
                // Requests are not looked at here; they stay pending until ARB.
                we_d  = 1'b1;
                wa_d  = cnt_q;
                wd_d  = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end
            end
`endif
            ST_ARB: begin
                if (bus.ramarbREQA || bus.ramarbREQB) begin
                    state_d  = ST_WRITE;
                    wa_d     = sel_addr;
                    wd_d     = sel_data;
                    // Out-of-range requests are still consumed, just never written.
                    we_d     = sel_ok;
                    err_d    = ~sel_ok;
                    gnta_d   = sel_a;
                    gntb_d   = ~sel_a;
                    last_b_d = ~sel_a;
                end
            end
            ST_WRITE: begin
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge ramarbCLK or negedge ramarbRSTN) begin
        if (!ramarbRSTN) begin
            state_q  <= RST_STATE;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            gnta_q   <= 1'b0;
            gntb_q   <= 1'b0;
            err_q    <= 1'b0;
            last_b_q <= 1'b1;
`ifdef RAMARB_INIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            gnta_q   <= gnta_d;
            gntb_q   <= gntb_d;
            err_q    <= err_d;
            last_b_q <= last_b_d;
`ifdef RAMARB_INIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.ramarbWE   = we_q;
    assign bus.ramarbWA   = wa_q;
    assign bus.ramarbWD   = wd_q;
    assign bus.ramarbGNTA = gnta_q;
    assign bus.ramarbGNTB = gntb_q;
    assign bus.ramarbERR  = err_q;
`ifdef RAMARB_INIT_EN
    assign bus.ramarbBUSY = (state_q == ST_INIT);
`else
    assign bus.ramarbBUSY = 1'b0;
`endif

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Purpose : self-checking bench for ram_write_arbiter (either build of RAMARB_INIT_EN).
// Latency : a cycle-level behavioural model predicts every output one edge ahead.
// Backpress: requesters are driven as well-behaved holders of REQ until GNT.
`timescale 1ns/1ps
module tb_ram_write_arbiter;
    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int DW    = 15;
`ifdef RAMARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam logic [DW-1:0] FILL = 15'h2AAA;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ram_write_arbiter_if #(.AW(AW), .DW(DW)) bus();

    ram_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .ramarbCLK  (clk),
        .ramarbRSTN (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // RAM as seen through the DUT write port, and RAM as the model says it must be.
    logic [DW-1:0] dut_ram [16] = '{default: FILL};
    logic [DW-1:0] exp_ram [16] = '{default: FILL};

    always @(posedge clk) begin
        if (bus.ramarbWE) dut_ram[bus.ramarbWA] <= bus.ramarbWD;
    end

    // ---------------- behavioural model ----------------
    // e_* are the outputs expected during the current cycle.
    logic          e_we, e_gnta, e_gntb, e_err, e_busy;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    int            m_busy_left;   // clear-writes still to issue after reset
    int            m_init_addr;
    bit            m_in_write;    // the cycle just finished was a grant cycle
    bit            m_last_b;
    logic          m_take_a;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    // A loses only when B also asks and A had the last grant.
    assign m_take_a = bus.ramarbREQA && !(bus.ramarbREQB && !m_last_b);
    assign m_addr   = m_take_a ? bus.ramarbWAA : bus.ramarbWAB;
    assign m_data   = m_take_a ? bus.ramarbWDA : bus.ramarbWDB;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_we <= 1'b0; e_wa <= '0; e_wd <= '0;
            e_gnta <= 1'b0; e_gntb <= 1'b0; e_err <= 1'b0;
            m_busy_left <= INIT_EN ? DEPTH : 0;
            e_busy      <= INIT_EN;
            m_init_addr <= 0;
            m_in_write  <= 1'b0;
            m_last_b    <= 1'b1;
        end else begin
            if (e_we) exp_ram[e_wa] <= e_wd;
            e_we <= 1'b0; e_gnta <= 1'b0; e_gntb <= 1'b0; e_err <= 1'b0;
            e_busy <= 1'b0;
            if (m_busy_left > 0) begin
                e_we        <= 1'b1;
                e_wa        <= AW'(m_init_addr);
                e_wd        <= '0;
                m_init_addr <= m_init_addr + 1;
                m_busy_left <= m_busy_left - 1;
                e_busy      <= (m_busy_left > 1);
            end else if (m_in_write) begin
                m_in_write <= 1'b0;
            end else if (bus.ramarbREQA || bus.ramarbREQB) begin
                e_gnta     <= m_take_a;
                e_gntb     <= !m_take_a;
                e_wa       <= m_addr;
                e_wd       <= m_data;
                e_we       <= (int'(m_addr) < DEPTH);
                e_err      <= !(int'(m_addr) < DEPTH);
                m_last_b   <= !m_take_a;
                m_in_write <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("we",   32'(bus.ramarbWE),   32'(e_we));
            check("gnta", 32'(bus.ramarbGNTA), 32'(e_gnta));
            check("gntb", 32'(bus.ramarbGNTB), 32'(e_gntb));
            check("err",  32'(bus.ramarbERR),  32'(e_err));
            check("busy", 32'(bus.ramarbBUSY), 32'(e_busy));
            check("wa",   32'(bus.ramarbWA),   32'(e_wa));
            check("wd",   32'(bus.ramarbWD),   32'(e_wd));
            check("no_double_grant", 32'(bus.ramarbGNTA & bus.ramarbGNTB), 0);
        end else begin
            check("we_in_reset", 32'(bus.ramarbWE), 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic one_write(input bit use_b, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int lat, output logic we_at, output logic err_at,
                             output logic [AW-1:0] wa_at, output logic [DW-1:0] wd_at);
        lat = -1; we_at = 1'b0; err_at = 1'b0; wa_at = '0; wd_at = '0;
        if (use_b) begin
            bus.ramarbREQB = 1'b1; bus.ramarbWAB = a; bus.ramarbWDB = d;
        end else begin
            bus.ramarbREQA = 1'b1; bus.ramarbWAA = a; bus.ramarbWDA = d;
        end
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (use_b ? bus.ramarbGNTB : bus.ramarbGNTA) begin
                lat = i; we_at = bus.ramarbWE; err_at = bus.ramarbERR;
                wa_at = bus.ramarbWA; wd_at = bus.ramarbWD;
            end
        end
        @(posedge clk); #1;
        if (use_b) bus.ramarbREQB = 1'b0;
        else       bus.ramarbREQA = 1'b0;
    endtask

    // Called at a falling edge; holds reset across one rising edge.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        bus.ramarbREQA = 1'b0;
        bus.ramarbREQB = 1'b0;
        #1 check({tag, "_we_drop"}, 32'(bus.ramarbWE), 0);
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    task automatic watch_restart(input string tag);
        int first;
        first = -1;
        for (int c = 0; c < 15 && first < 0; c++) begin
            @(negedge clk);
            if (bus.ramarbWE) begin
                first = c;
                check({tag, "_first_wa"}, 32'(bus.ramarbWA), 0);
            end
        end
        check({tag, "_first_we_cycle"}, 32'(first), INIT_EN ? 1 : -1);
        for (int c = 0; c < 30 && bus.ramarbBUSY; c++) @(negedge clk);
        check({tag, "_idle"}, 32'(bus.ramarbBUSY), 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat, gc, busy_cnt, init_we, n, found, cnt7777;
        logic we_at, err_at, g;
        logic [AW-1:0] wa_at;
        logic [DW-1:0] wd_at;
        int seq [16];
        int cyc [16];

        bus.ramarbREQA = 1'b0; bus.ramarbWAA = '0; bus.ramarbWDA = '0;
        bus.ramarbREQB = 1'b0; bus.ramarbWAB = '0; bus.ramarbWDB = '0;

        // Power-up clear with A already requesting word 4 during reset.
        bus.ramarbREQA = 1'b1; bus.ramarbWAA = 4'd4; bus.ramarbWDA = 15'h0444;
        #12 check("reset_we",   32'(bus.ramarbWE),   0);
        check("reset_wa",   32'(bus.ramarbWA),   0);
        check("reset_gnta", 32'(bus.ramarbGNTA), 0);
        #16 rst_n = 1'b1;
        busy_cnt = 0; init_we = 0; gc = -1;
        for (int c = 0; c < 40 && gc < 0; c++) begin
            @(negedge clk);
            if (bus.ramarbBUSY) busy_cnt++;
            if (bus.ramarbGNTA) begin
                gc = c;
                check("pend_wa", 32'(bus.ramarbWA), 4);
                check("pend_we", 32'(bus.ramarbWE), 1);
            end else if (bus.ramarbWE) begin
                check("init_wa", 32'(bus.ramarbWA), 32'(init_we));
                check("init_wd", 32'(bus.ramarbWD), 0);
                init_we++;
            end
        end
        check("pend_gnt_cycle", 32'(gc), INIT_EN ? 11 : 1);
        check("busy_cycles",    32'(busy_cnt), INIT_EN ? 10 : 0);
        check("init_writes",    32'(init_we),  INIT_EN ? 10 : 0);
        @(posedge clk); #1 bus.ramarbREQA = 1'b0;
        check("readback_w0", 32'(dut_ram[0]), INIT_EN ? 0 : 32'(FILL));
        check("readback_w9", 32'(dut_ram[9]), INIT_EN ? 0 : 32'(FILL));
        check("readback_w4", 32'(dut_ram[4]), 32'h0444);

        // Single A write to word 3.
        one_write(1'b0, 4'd3, 15'h1234, lat, we_at, err_at, wa_at, wd_at);
        check("a3_lat", 32'(lat), 1);
        check("a3_we",  32'(we_at), 1);
        check("a3_wa",  32'(wa_at), 3);
        check("a3_wd",  32'(wd_at), 32'h1234);
        check("a3_ram", 32'(dut_ram[3]), 32'h1234);

        // B to address 12: consumed, flagged, not written.
        one_write(1'b1, 4'd12, 15'h7777, lat, we_at, err_at, wa_at, wd_at);
        check("b12_lat", 32'(lat), 1);
        check("b12_we",  32'(we_at), 0);
        check("b12_err", 32'(err_at), 1);

        // Both requesting continuously; B went last, so A leads.
        bus.ramarbREQA = 1'b1; bus.ramarbWAA = 4'd1; bus.ramarbWDA = 15'h0A01;
        bus.ramarbREQB = 1'b1; bus.ramarbWAB = 4'd2; bus.ramarbWDB = 15'h0B02;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if ((bus.ramarbGNTA || bus.ramarbGNTB) && n < 16) begin
                seq[n] = bus.ramarbGNTB ? 1 : 0;
                cyc[n] = c;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.ramarbREQA = 1'b0; bus.ramarbREQB = 1'b0;
        check("rr_grants", 32'(n), 8);
        for (int k = 0; k < n; k++) begin
            check("rr_order", 32'(seq[k]), 32'(k % 2));
            check("rr_cycle", 32'(cyc[k]), 32'(2 * k + 1));
        end
        check("rr_ram1", 32'(dut_ram[1]), 32'h0A01);
        check("rr_ram2", 32'(dut_ram[2]), 32'h0B02);
        cnt7777 = 0;
        for (int i = 0; i < 16; i++) if (dut_ram[i] == 15'h7777) cnt7777++;
        check("b12_nowrite", 32'(cnt7777), 0);

        // Reset while A's write to word 7 is in its WRITE cycle.
        bus.ramarbREQA = 1'b1; bus.ramarbWAA = 4'd7; bus.ramarbWDA = 15'h0777;
        g = 1'b0;
        for (int i = 0; i < 10 && !g; i++) begin
            @(negedge clk);
            if (bus.ramarbGNTA) g = 1'b1;
        end
        check("a7_gnt", 32'(g), 1);
        reset_pulse("wr");
        watch_restart("wr");
        check("a7_aborted", 32'(dut_ram[7] == 15'h0777), 0);

        // Reset when the clear sequence reaches word 5.
        reset_pulse("idle");
        found = 0;
        for (int c = 0; c < 15 && found == 0; c++) begin
            @(negedge clk);
            if (bus.ramarbWE && bus.ramarbWA == 4'd5) found = 1;
        end
        check("init5_seen", 32'(found), 32'(INIT_EN));
        if (found != 0) reset_pulse("init5");
        watch_restart("init5");

        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) check("final_ram", 32'(dut_ram[i]), 32'(exp_ram[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
